// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the keypad scanner
// Contents:
//   NUM_ROWS, NUM_COLS, KEY_W : matrix geometry and key code width
//   kp_state_e                : scanner FSM states
//   prio_row()                : lowest-index low row of an active-low row vector
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_REPORT   = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  // Row 0 has the highest priority. All-high input returns 0, so callers
  // must qualify the result with "some row is low".
  function automatic logic [1:0] prio_row(input logic [3:0] rows_n);
    prio_row = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) prio_row = i[1:0];
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key handshake bus between scanner and CPU register
// Signals:
//   key_code  : encoded key, row*4 + col
//   key_valid : key_code holds an unconsumed key
//   key_ready : consumer accepts key_code when key_valid is high
//   key_held  : debounced key currently down
//   overflow  : sticky, a key was dropped because the previous one was pending
//   ovf_clr   : synchronous clear of overflow
// Modports: master = scanner side, slave = consumer side.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ready;
  logic             key_held;
  logic             overflow;
  logic             ovf_clr;

  modport master (
    output key_code, key_valid, key_held, overflow,
    input  key_ready, ovf_clr
  );

  modport slave (
    input  key_code, key_valid, key_held, overflow,
    output key_ready, ovf_clr
  );
endinterface

// File: rtl/keypad_tick.sv
// rtl/keypad_tick.sv - free-running single-cycle scan tick enable
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   tick  : high for one clk every SCAN_DIV clks (when count == SCAN_DIV-1)
module keypad_tick #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count_q <= '0;
    else if (tick) count_q <= '0;
    else           count_q <= count_q + 1'b1;
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan, debounce, encode and handshake
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high
//   rows_n : matrix rows, active-low, asynchronous to clk
//   cols_n : column drive, active-low one-hot
//   kbus   : key handshake bus (master side), see keypad_scanner_if
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          rows_n,
  output logic [3:0]          cols_n,
  keypad_scanner_if.master    kbus
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);

  logic             tick;
  logic [3:0]       rs_meta, rs;
  kp_state_e        state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       prow_q, prow_d;
  logic [DB_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             any_low;

  keypad_tick #(.SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_meta <= 4'hF;
      rs      <= 4'hF;
    end else begin
      rs_meta <= rows_n;
      rs      <= rs_meta;
    end
  end

  assign any_low = ~&rs;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      prow_q  <= 2'd0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      prow_q  <= prow_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    prow_d  = prow_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    // Transfer and clear first; a REPORT load or overflow set below wins.
    if (valid_q && kbus.key_ready) valid_d = 1'b0;
    if (kbus.ovf_clr)              ovf_d   = 1'b0;

    unique case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (any_low) begin
            prow_d  = prio_row(rs);
            cnt_d   = DB_W'(1);
            state_d = (DEBOUNCE == 1) ? ST_REPORT : ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (tick) begin
          if (any_low && (prio_row(rs) == prow_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) state_d = ST_REPORT;
          end else begin
            col_d   = col_q + 2'd1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_REPORT: begin
        if (!valid_q || kbus.key_ready) begin
          code_d  = {prow_q, col_q};
          valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (tick) begin
          if (rs == 4'hF) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              col_d   = col_q + 2'd1;
              state_d = ST_SCAN;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  assign cols_n         = ~(4'b0001 << col_q);
  assign kbus.key_code  = code_q;
  assign kbus.key_valid = valid_q;
  assign kbus.key_held  = (state_q == ST_RELEASE);
  assign kbus.overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic [15:0] pressed;

  int n_checks = 0;
  int n_pass   = 0;
  int xfer_count = 0;
  logic [3:0] exp_q[$];

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3), .CNT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .rows_n (rows_n),
    .cols_n (cols_n),
    .kbus   (kif)
  );

  always #5 clk = ~clk;

  // Switch matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Scoreboard: every handshake transfer pops one expected key code.
  always @(negedge clk) begin
    if (!reset && kif.key_valid && kif.key_ready) begin
      xfer_count++;
      if (exp_q.size() == 0) check("unexpected_xfer", {28'd0, kif.key_code}, 32'hFFFF_FFFF);
      else check("xfer_code", kif.key_code, exp_q.pop_front());
    end
  end

  task automatic wait_held(input logic v, input int maxc, input string tag, output int cyc);
    cyc = 0;
    while (kif.key_held !== v && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, kif.key_held, v);
  endtask

  task automatic wait_cols(input logic [3:0] v, input int maxc, input string tag);
    int n;
    n = 0;
    while (cols_n !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, cols_n, v);
  endtask

  logic [3:0] exp_c;
  logic [3:0] prev_c;
  int n, cyc, base_xfer;
  logic saw_valid;

  initial begin
    reset = 1'b1;
    pressed = '0;
    kif.key_ready = 1'b1;
    kif.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cols", cols_n, 4'b1110);
    check("rst_valid", kif.key_valid, 1'b0);
    check("rst_held", kif.key_held, 1'b0);
    check("rst_ovf", kif.overflow, 1'b0);
    check("rst_code", kif.key_code, 4'd0);
    reset = 1'b0;

    // Idle rotation, one column step per 4 clks
    exp_c = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      prev_c = cols_n;
      n = 0;
      while (cols_n === prev_c && n < 10) begin
        @(negedge clk);
        n++;
      end
      exp_c = {exp_c[2:0], exp_c[3]};
      check("idle_cols", cols_n, exp_c);
      if (i > 0) check("idle_period", n, 4);
    end
    check("idle_valid", kif.key_valid, 1'b0);

    // Clean press of key 9 (row 2, col 1)
    exp_q.push_back(4'd9);
    pressed[9] = 1'b1;
    wait_held(1'b1, 60, "press9_held", cyc);
    repeat (8) @(negedge clk);
    check("press9_still_held", kif.key_held, 1'b1);
    pressed[9] = 1'b0;
    wait_held(1'b0, 40, "press9_release", cyc);
    check("press9_release_slow", cyc >= 8, 1'b1);
    check("press9_next_col", cols_n, 4'b1011);
    check("press9_xfers", xfer_count, 1);

    // Bounce: row 0 low on column 3 for a single tick
    base_xfer = xfer_count;
    wait_cols(4'b0111, 10, "bounce_col3");
    pressed[3] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    pressed[3] = 1'b0;
    check("bounce_col_held", cols_n, 4'b0111);
    prev_c = cols_n;
    n = 0;
    while (cols_n === prev_c && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bounce_next_col", cols_n, 4'b1110);
    check("bounce_no_xfer", xfer_count, base_xfer);
    check("bounce_not_held", kif.key_held, 1'b0);

    // Multi-key: rows 1 and 3 on column 0, row 1 wins
    exp_q.push_back(4'd4);
    pressed[4] = 1'b1;
    pressed[12] = 1'b1;
    wait_held(1'b1, 60, "multi_held", cyc);
    pressed[4] = 1'b0;
    pressed[12] = 1'b0;
    wait_held(1'b0, 40, "multi_release", cyc);

    // Backpressure: key 5 pending, key 10 dropped
    kif.key_ready = 1'b0;
    exp_q.push_back(4'd5);
    pressed[5] = 1'b1;
    wait_held(1'b1, 60, "bp5_held", cyc);
    pressed[5] = 1'b0;
    wait_held(1'b0, 40, "bp5_release", cyc);
    check("bp5_valid", kif.key_valid, 1'b1);
    check("bp5_code", kif.key_code, 4'd5);
    pressed[10] = 1'b1;
    wait_held(1'b1, 60, "bp10_held", cyc);
    @(negedge clk);
    check("bp10_ovf", kif.overflow, 1'b1);
    check("bp10_code_kept", kif.key_code, 4'd5);
    check("bp10_valid", kif.key_valid, 1'b1);
    pressed[10] = 1'b0;
    wait_held(1'b0, 40, "bp10_release", cyc);
    kif.key_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", kif.key_valid, 1'b0);
    check("bp_ovf_sticky", kif.overflow, 1'b1);
    kif.ovf_clr = 1'b1;
    @(negedge clk);
    kif.ovf_clr = 1'b0;
    check("bp_ovf_clr", kif.overflow, 1'b0);

    // Reset during the second debounce tick, with a pending key and overflow
    kif.key_ready = 1'b0;
    pressed[15] = 1'b1;
    wait_held(1'b1, 60, "pre15_held", cyc);
    pressed[15] = 1'b0;
    wait_held(1'b0, 40, "pre15_release", cyc);
    pressed[0] = 1'b1;
    wait_held(1'b1, 60, "pre0_held", cyc);
    pressed[0] = 1'b0;
    wait_held(1'b0, 40, "pre0_release", cyc);
    check("pre_rst_valid", kif.key_valid, 1'b1);
    check("pre_rst_ovf", kif.overflow, 1'b1);
    pressed[6] = 1'b1;
    wait_cols(4'b1011, 20, "rst_col2");
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_cols", cols_n, 4'b1110);
    check("mid_rst_valid", kif.key_valid, 1'b0);
    check("mid_rst_ovf", kif.overflow, 1'b0);
    check("mid_rst_held", kif.key_held, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    kif.key_ready = 1'b1;
    exp_q.push_back(4'd6);
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (kif.key_valid) saw_valid = 1'b1;
    end
    check("post_rst_no_early", saw_valid, 1'b0);
    wait_held(1'b1, 60, "post_rst_held", cyc);
    pressed[6] = 1'b0;
    wait_held(1'b0, 40, "post_rst_release", cyc);
    repeat (2) @(negedge clk);

    check("sb_empty", exp_q.size(), 0);
    check("xfer_total", xfer_count, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
